irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 Port: reset_n  input  1  reset; asynchronous, active-low.
REQ-003 Port: src  input  8  interrupt sources, asynchronous to clk; bit 0 has highest priority.
REQ-004 Port: sel  input  1  register access strobe.
REQ-005 Port: we  input  1  write enable; qualifies sel.
REQ-006 Port: addr  input  2  register select: 0 PENDING, 1 MASK, 2 VBASE, 3 CLAIM.
REQ-007 Port: wdata  input  32  write data.
REQ-008 Port: rdata  output  32  registered read data, valid one cycle after a read strobe.
REQ-009 Port: irq  output  1  interrupt request to the CPU.
REQ-010 Port: xadr  output  31  handler address presented alongside irq.

Function
REQ-011 Each src bit SHALL pass through a two-flop synchronizer before any further use.
REQ-012 Pending bit i SHALL set on a synchronized 0->1 edge of src[i]; it stays set until claimed or cleared.
REQ-013 PENDING register: read returns {24'b0, pending}; a write clears every bit where wdata[i]=1 (write-1-to-clear).
REQ-014 A set edge and a clear on the same bit in the same cycle SHALL leave the bit set.
REQ-015 MASK register: read/write, bits 7:0; bit=1 enables the source; bits 31:8 read 0.
REQ-016 VBASE register: read/write, bits 30:0; bit 31 reads 0.
REQ-017 active = pending & mask; id = lowest index set in active (fixed priority).
REQ-018 xadr SHALL equal VBASE + 4*id, computed modulo 2^31.
REQ-019 FSM states: IDLE, ASSERT, SERVICE; the encoding is free.
REQ-020 IDLE -> ASSERT on the clock edge where active != 0.
REQ-021 ASSERT -> IDLE on the clock edge where active == 0; this covers a mask change or a PENDING clear. id re-evaluates every cycle while in ASSERT.
REQ-022 irq SHALL equal 1 exactly when state is ASSERT.
REQ-023 A CLAIM read in ASSERT does three things: returns {1'b1, 28'b0, id} in rdata the next cycle, clears pending[id], and moves the FSM to SERVICE.
REQ-024 A CLAIM read in IDLE or SERVICE returns {1'b0, 28'b0, last claimed id} and has no side effects.
REQ-025 A CLAIM write (EOI) in SERVICE moves the FSM to IDLE; a CLAIM write in any other state is ignored.
REQ-026 Pending edges arriving during SERVICE are recorded; irq stays 0 until after EOI.
REQ-027 Read latency is 1 cycle; rdata holds its value when sel=0.
REQ-028 Total latency: a src rise meeting setup before edge n gives pending set at edge n+2 and irq=1 at edge n+3, provided the source is masked-in and the FSM is in IDLE.

Reset
REQ-029 reset_n=0 SHALL asynchronously clear synchronizers, pending, MASK, VBASE, last-claimed id and rdata to 0, and force state to IDLE.
REQ-030 Reset outputs: irq=0, xadr=0, rdata=0.
REQ-031 Reset deassertion mid-operation SHALL leave no stale pending bit or irq; edge detection restarts from synchronized value 0.

Configuration
REQ-032 Macro IRQ_EDGE_EN defined: pending behaviour is edge-triggered and sticky per REQ-012..014.
REQ-033 Macro IRQ_EDGE_EN undefined: level-triggered mode.
  - pending equals the synchronized src level.
  - PENDING writes have no effect.
  - A CLAIM read does not clear any pending bit.
  - All other behaviour is unchanged.

Verification
REQ-034 Reset test: reset_n=0 mid-ASSERT -> irq=0, xadr=0 and PENDING reads 0 immediately; MASK reads 0 after release.
REQ-035 Priority and vector: VBASE=0x1000, MASK=0xFF, src[5] and src[2] rise together -> irq=1 with xadr=0x1008 three edges later; CLAIM read returns 0x80000002; irq then drops; xadr becomes 0x1014.
REQ-036 Service and EOI: in SERVICE, src[1] rises -> irq stays 0; CLAIM write -> IDLE, and irq=1 with xadr=VBASE+4 the following edge.
REQ-037 Mask and clear: in ASSERT on id 3, clear MASK bit 3 -> irq=0 next edge, PENDING still reads 0x08; write PENDING=0x08 -> PENDING reads 0.
REQ-038 Set wins: src[4] edge reaches pending in the same cycle as PENDING write 0x10 -> PENDING reads 0x10.
REQ-039 Wrap: VBASE=0x7FFFFFFC, id 2 -> xadr=0x00000004.

Source files
------------

// File: rtl/irq_ctrl.sv
// Eight-source interrupt controller: synchronized sources, priority vectoring, claim/EOI.
// Define IRQ_EDGE_EN for sticky edge-triggered pending; default is level-triggered.
module irq_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  src,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [30:0] xadr
);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    SERVICE
  } state_e;

  localparam logic [1:0] A_PEND  = 2'd0;
  localparam logic [1:0] A_MASK  = 2'd1;
  localparam logic [1:0] A_VBASE = 2'd2;
  localparam logic [1:0] A_CLAIM = 2'd3;

  logic [7:0]  sync1_q, sync2_q;
  logic [7:0]  pend_q, pend_d;
  logic [7:0]  mask_q, mask_d;
  logic [30:0] vbase_q, vbase_d;
  logic [2:0]  last_id_q, last_id_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q;
  state_e      state_q, state_d;

  logic [7:0]  active;
  logic [2:0]  id;
  logic        rd_en, wr_en;
  logic        claim_go, eoi;
  logic        unused_ok;

  assign rd_en     = sel & ~we;
  assign wr_en     = sel & we;
  assign claim_go  = rd_en && (addr == A_CLAIM) && (state_q == ASSERT);
  assign eoi       = wr_en && (addr == A_CLAIM) && (state_q == SERVICE);
  assign unused_ok = wdata[31];

  assign active = pend_q & mask_q;

  always_comb begin
    id = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) id = 3'(i);
    end
  end

  assign xadr  = vbase_q + {26'b0, id, 2'b00};
  assign irq   = irq_q;
  assign rdata = rdata_q;

`ifdef IRQ_EDGE_EN
  logic [7:0] prev_q;
  logic [7:0] rise, clr;

  // Clear first, then OR in new edges so a same-cycle edge wins.
  always_comb begin
    rise = sync2_q & ~prev_q;
    clr  = 8'b0;
    if (wr_en && (addr == A_PEND)) clr = clr | wdata[7:0];
    if (claim_go) clr = clr | (8'b1 << id);
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_q <= 8'b0;
    else          prev_q <= sync2_q;
  end
`else
  // Registered copy keeps the same src-to-irq latency as edge mode.
  always_comb begin
    pend_d = sync2_q;
  end
`endif

  always_comb begin
    mask_d    = mask_q;
    vbase_d   = vbase_q;
    last_id_d = last_id_q;
    if (wr_en && (addr == A_MASK))  mask_d  = wdata[7:0];
    if (wr_en && (addr == A_VBASE)) vbase_d = wdata[30:0];
    if (claim_go) last_id_d = id;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      unique case (addr)
        A_PEND:  rdata_d = {24'b0, pend_q};
        A_MASK:  rdata_d = {24'b0, mask_q};
        A_VBASE: rdata_d = {1'b0, vbase_q};
        A_CLAIM: rdata_d = claim_go ? {1'b1, 28'b0, id}
                                    : {1'b0, 28'b0, last_id_q};
        default: rdata_d = rdata_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|active) state_d = ASSERT;
      ASSERT: begin
        if (claim_go)      state_d = SERVICE;
        else if (~|active) state_d = IDLE;
      end
      SERVICE: if (eoi) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 8'b0;
      sync2_q   <= 8'b0;
      pend_q    <= 8'b0;
      mask_q    <= 8'b0;
      vbase_q   <= 31'b0;
      last_id_q <= 3'b0;
      rdata_q   <= 32'b0;
      state_q   <= IDLE;
      irq_q     <= 1'b0;
    end else begin
      sync1_q   <= src;
      sync2_q   <= sync1_q;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      vbase_q   <= vbase_d;
      last_id_q <= last_id_d;
      rdata_q   <= rdata_d;
      state_q   <= state_d;
      irq_q     <= (state_d == ASSERT);
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register table plus claim/EOI, mask, wrap and reset sequences.
// Expectations follow IRQ_EDGE_EN when defined, level mode otherwise.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  src;
  logic        sel, we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic [30:0] xadr;

  int ncmp = 0;
  int nerr = 0;

  irq_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .src     (src),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq),
    .xadr    (xadr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        w;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tab[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Tasks start and end just after a falling edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    sel = 1'b0;
    d = rdata;
  endtask

  task automatic waitn(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] got;

  initial begin
    tab[0]  = '{"mask_w",   1'b1, 2'd1, 32'hFFFF_FF5A, 32'h0};
    tab[1]  = '{"mask_r",   1'b0, 2'd1, 32'h0,         32'h0000_005A};
    tab[2]  = '{"vbase_w",  1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0};
    tab[3]  = '{"vbase_r",  1'b0, 2'd2, 32'h0,         32'h7FFF_FFFF};
    tab[4]  = '{"pend_r",   1'b0, 2'd0, 32'h0,         32'h0};
    tab[5]  = '{"claim_r",  1'b0, 2'd3, 32'h0,         32'h0};
    tab[6]  = '{"eoi_idle", 1'b1, 2'd3, 32'h1,         32'h0};
    tab[7]  = '{"claim_r2", 1'b0, 2'd3, 32'h0,         32'h0};
    tab[8]  = '{"vbase_w2", 1'b1, 2'd2, 32'h0000_1000, 32'h0};
    tab[9]  = '{"vbase_r2", 1'b0, 2'd2, 32'h0,         32'h0000_1000};
    tab[10] = '{"mask_w2",  1'b1, 2'd1, 32'h0000_00FF, 32'h0};
    tab[11] = '{"mask_r2",  1'b0, 2'd1, 32'h0,         32'h0000_00FF};

    reset_n = 1'b0;
    src = 8'h0; sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'h0;
    waitn(2);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_xadr", {1'b0, xadr}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    reset_n = 1'b1;
    waitn(1);

    for (int i = 0; i < 12; i++) begin
      if (tab[i].w) begin
        wr(tab[i].a, tab[i].d);
      end else begin
        rd(tab[i].a, got);
        chk(tab[i].nm, got, tab[i].exp);
      end
    end
    chk("tab_irq", {31'b0, irq}, 32'h0);

    // Priority and vector: src 5 and 2 together
    src = 8'h24;
    waitn(3);
    chk("lat_n2_irq", {31'b0, irq}, 32'h0);
    waitn(1);
    chk("lat_n3_irq", {31'b0, irq}, 32'h1);
    chk("prio_xadr", {1'b0, xadr}, 32'h0000_1008);
    rd(2'd3, got);
    chk("claim2", got, 32'h8000_0002);
    chk("svc_irq", {31'b0, irq}, 32'h0);
`ifdef IRQ_EDGE_EN
    chk("svc_xadr", {1'b0, xadr}, 32'h0000_1014);
`else
    chk("svc_xadr", {1'b0, xadr}, 32'h0000_1008);
`endif

    // New edge while in service stays hidden until EOI
    src = 8'h26;
    waitn(4);
    chk("svc_hold", {31'b0, irq}, 32'h0);
    rd(2'd0, got);
`ifdef IRQ_EDGE_EN
    chk("svc_pend", got, 32'h0000_0022);
`else
    chk("svc_pend", got, 32'h0000_0026);
`endif
    rd(2'd3, got);
    chk("claim_svc", got, 32'h0000_0002);
    wr(2'd3, 32'h0);
    chk("eoi_idle", {31'b0, irq}, 32'h0);
    waitn(1);
    chk("eoi_irq", {31'b0, irq}, 32'h1);
    chk("eoi_xadr", {1'b0, xadr}, 32'h0000_1004);
    rd(2'd3, got);
    chk("claim1", got, 32'h8000_0001);
    src = 8'h00;
    waitn(4);
    wr(2'd0, 32'hFF);
    wr(2'd3, 32'h0);
    waitn(2);
    chk("clean_irq", {31'b0, irq}, 32'h0);
    rd(2'd0, got);
    chk("clean_pend", got, 32'h0);

    // Mask removal drops irq; pending survives
    src = 8'h08;
    waitn(4);
    chk("m_irq", {31'b0, irq}, 32'h1);
    chk("m_xadr", {1'b0, xadr}, 32'h0000_100C);
    wr(2'd1, 32'hF7);
    chk("m_irq_hold", {31'b0, irq}, 32'h1);
    waitn(1);
    chk("m_irq_drop", {31'b0, irq}, 32'h0);
    rd(2'd0, got);
    chk("m_pend", got, 32'h0000_0008);
    wr(2'd0, 32'h08);
    rd(2'd0, got);
`ifdef IRQ_EDGE_EN
    chk("m_w1c", got, 32'h0);
`else
    chk("m_w1c", got, 32'h0000_0008);
`endif
    src = 8'h00;
    waitn(4);
    wr(2'd1, 32'hFF);
    waitn(1);
    chk("m_idle", {31'b0, irq}, 32'h0);

    // Set edge coincides with a write-1-to-clear
    src = 8'h10;
    waitn(2);
    wr(2'd0, 32'h10);
    rd(2'd0, got);
    chk("set_wins", got, 32'h0000_0010);
    wr(2'd0, 32'h10);
    rd(2'd0, got);
`ifdef IRQ_EDGE_EN
    chk("w1c_later", got, 32'h0);
`else
    chk("w1c_later", got, 32'h0000_0010);
`endif
    src = 8'h00;
    waitn(4);
    chk("sw_idle", {31'b0, irq}, 32'h0);

    // Vector wrap modulo 2^31
    wr(2'd2, 32'h7FFF_FFFC);
    src = 8'h04;
    waitn(4);
    chk("wrap_irq", {31'b0, irq}, 32'h1);
    chk("wrap_xadr", {1'b0, xadr}, 32'h0000_0004);

    // Asynchronous reset in the middle of ASSERT
    reset_n = 1'b0;
    src = 8'h00;
    #1;
    chk("ar_irq", {31'b0, irq}, 32'h0);
    chk("ar_xadr", {1'b0, xadr}, 32'h0);
    chk("ar_rdata", rdata, 32'h0);
    waitn(1);
    reset_n = 1'b1;
    waitn(1);
    rd(2'd1, got);
    chk("ar_mask", got, 32'h0);
    rd(2'd0, got);
    chk("ar_pend", got, 32'h0);
    rd(2'd2, got);
    chk("ar_vbase", got, 32'h0);
    rd(2'd3, got);
    chk("ar_lastid", got, 32'h0);
    chk("ar_irq2", {31'b0, irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
